// File: rtl/compositor_pkg.sv
// Shared types, default geometry and the layer-priority helper for layer_compositor.
package compositor_pkg;

  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_IDX_W      = 4;
  localparam int DEF_NUM_BANKS  = 2;
  localparam int DEF_COLOR_W    = 24;

  localparam int MAX_LAYERS = 16;
  localparam int MAX_IDX_W  = 8;
  localparam int PAD_W      = MAX_LAYERS * MAX_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    ACK  = 2'd2
  } wr_state_t;

  // Sized for the largest supported stack; callers zero-pad and pass their real geometry.
  function automatic logic [MAX_IDX_W-1:0] first_opaque(
    input logic [PAD_W-1:0]      idx_vec,
    input logic [MAX_LAYERS-1:0] en_vec,
    input int                    num_layers,
    input int                    idx_w
  );
    logic [MAX_IDX_W-1:0] mask;
    logic [MAX_IDX_W-1:0] cur;
    logic [MAX_IDX_W-1:0] result;
    mask   = MAX_IDX_W'((1 << idx_w) - 1);
    result = '0;
    for (int k = MAX_LAYERS - 1; k >= 0; k--) begin
      cur = MAX_IDX_W'(idx_vec >> (k * idx_w)) & mask;
      if (k < num_layers && en_vec[k] && cur != '0) result = cur;
    end
    return result;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: registered read, read-before-write on address collision.
module palette_ram
  import compositor_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               Clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [DEPTH];

  // No reset so the array maps onto block RAM; a colliding read sees the old word.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_compositor.sv
// Prioritised multi-layer colour-index compositor with a banked, CPU-writable palette.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pixel_valid,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [BANK_W-1:0]           bank_sel,
  input  logic                        pal_we,
  input  logic [BANK_W-1:0]           pal_bank,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [COLOR_W-1:0]          pal_data,
  output logic                        pal_ack,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic [BANK_W-1:0]           active_bank
);

  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** IDX_W);

  logic               bank_sel_ok;
  logic [BANK_W-1:0]  eff_bank;
  logic [IDX_W-1:0]   win_idx;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [COLOR_W-1:0] rd_data;

  wr_state_t          state;
  logic [BANK_W-1:0]  wr_bank;
  logic [IDX_W-1:0]   wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_bank_ok;
  logic               ram_we;

  // Out-of-range bank requests are dropped so the displayed bank always exists.
  assign bank_sel_ok = int'(bank_sel) < NUM_BANKS;
  assign eff_bank    = (frame_start && bank_sel_ok) ? bank_sel : active_bank;
  assign win_idx     = IDX_W'(first_opaque(PAD_W'(layer_idx), MAX_LAYERS'(layer_en),
                                           NUM_LAYERS, IDX_W));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      out_valid   <= 1'b0;
      active_bank <= '0;
    end else begin
      s1_valid  <= pixel_valid;
      s1_addr   <= {eff_bank, win_idx};
      out_valid <= s1_valid;
      if (frame_start && bank_sel_ok) active_bank <= bank_sel;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (pal_we) state <= WR;
        WR:      state <= ACK;
        ACK:     if (!pal_we) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are captured once so the CPU may change them while waiting for ack.
  always_ff @(posedge Clk) begin
    if (state == IDLE && pal_we) begin
      wr_bank <= pal_bank;
      wr_addr <= pal_addr;
      wr_data <= pal_data;
    end
  end

  assign wr_bank_ok = int'(wr_bank) < NUM_BANKS;
  assign ram_we     = (state == WR) && wr_bank_ok;
  assign pal_ack    = (state == ACK);

  palette_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .COLOR_W(COLOR_W)
  ) u_palette_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .waddr({wr_bank, wr_addr}),
    .wdata(wr_data),
    .raddr(s1_addr),
    .rdata(rd_data)
  );

  assign VGA_R = out_valid ? rd_data[COLOR_W-1  -: 8] : 8'd0;
  assign VGA_G = out_valid ? rd_data[COLOR_W-9  -: 8] : 8'd0;
  assign VGA_B = out_valid ? rd_data[COLOR_W-17 -: 8] : 8'd0;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: random and directed pixels against a palette model.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int IW = 4;
  localparam int NB = 3;
  localparam int CW = 24;
  localparam int BW = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              Reset_n;
  logic              pixel_valid;
  logic              frame_start;
  logic [NL*IW-1:0]  layer_idx;
  logic [NL-1:0]     layer_en;
  logic [BW-1:0]     bank_sel;
  logic              pal_we;
  logic [BW-1:0]     pal_bank;
  logic [IW-1:0]     pal_addr;
  logic [CW-1:0]     pal_data;
  logic              pal_ack;
  logic [7:0]        VGA_R;
  logic [7:0]        VGA_G;
  logic [7:0]        VGA_B;
  logic              out_valid;
  logic [BW-1:0]     active_bank;

  layer_compositor #(
    .NUM_LAYERS(NL),
    .IDX_W     (IW),
    .NUM_BANKS (NB),
    .COLOR_W   (CW)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .layer_idx  (layer_idx),
    .layer_en   (layer_en),
    .bank_sel   (bank_sel),
    .pal_we     (pal_we),
    .pal_bank   (pal_bank),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .pal_ack    (pal_ack),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .out_valid  (out_valid),
    .active_bank(active_bank)
  );

  logic [23:0] pal_model [NB][16];
  int          bank_model;
  logic [23:0] exp_q [$];
  logic [23:0] exp_val;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first enabled non-zero layer wins, otherwise the backdrop entry.
  function automatic logic [23:0] model_pixel(input logic [15:0] idx, input logic [3:0] en,
                                              input int bank);
    int sel = 0;
    for (int k = 0; k < NL; k++) begin
      int v;
      v = int'((idx >> (4 * k)) & 16'hF);
      if (en[k] && v != 0) begin
        sel = v;
        break;
      end
    end
    return pal_model[bank][sel];
  endfunction

  task automatic applyStimulus(input logic v, input logic fs, input logic [15:0] idx,
                               input logic [3:0] en, input logic [1:0] bs);
    int eff = bank_model;
    if (fs && int'(bs) < NB) eff = int'(bs);
    pixel_valid = v;
    frame_start = fs;
    layer_idx   = idx;
    layer_en    = en;
    bank_sel    = bs;
    if (v) exp_q.push_back(model_pixel(idx, en, eff));
    @(posedge Clk); #1;
    bank_model  = eff;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 2'd0);
  endtask

  task automatic palWrite(input logic [1:0] b, input logic [3:0] a, input logic [23:0] d);
    int n = 0;
    pal_we   = 1'b1;
    pal_bank = b;
    pal_addr = a;
    pal_data = d;
    while (!pal_ack && n < 8) begin
      @(posedge Clk); #1;
      n++;
    end
    checkOutput("wr_ack", {31'd0, pal_ack}, 32'd1);
    checkOutput("wr_ack_latency", n, 32'd2);
    pal_we = 1'b0;
    @(posedge Clk); #1;
    if (int'(b) < NB) pal_model[b][a] = d;
  endtask

  task automatic doReset(input int cycles);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pal_we      = 1'b0;
    Reset_n     = 1'b0;
    repeat (cycles) @(posedge Clk);
    #1;
    exp_q.delete();
    bank_model = 0;
    Reset_n    = 1'b1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    checkOutput("rst_pal_ack", {31'd0, pal_ack}, 32'd0);
    checkOutput("rst_active_bank", {30'd0, active_bank}, 32'd0);
  endtask

  task automatic randomStream(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] idx;
      for (int k = 0; k < NL; k++)
        idx[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, idx,
                    4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
  endtask

  // Monitor: pops one expectation per presented pixel, independent of the stimulus thread.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pixel: got %h%h%h, expected no pixel", VGA_R, VGA_G, VGA_B);
        end else begin
          exp_val = exp_q.pop_front();
          checkOutput("pixel_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_val});
        end
      end else begin
        checkOutput("idle_rgb_zero", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      end
      checkOutput("active_bank", {30'd0, active_bank}, bank_model);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_n     = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    layer_idx   = '0;
    layer_en    = '0;
    bank_sel    = '0;
    pal_we      = 1'b0;
    pal_bank    = '0;
    pal_addr    = '0;
    pal_data    = '0;
    bank_model  = 0;
    doReset(2);
    mon_en = 1'b1;

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 16; a++)
        palWrite(2'(b), 4'(a), 24'($urandom));

    palWrite(2'd0, 4'd3, 24'hFF0000);
    palWrite(2'd0, 4'd0, 24'h000080);
    palWrite(2'd0, 4'd5, 24'h00FF00);
    palWrite(2'd1, 4'd3, 24'h00FF00);

    applyStimulus(1'b1, 1'b0, 16'h0030, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0035, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0035, 4'hE, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0530, 4'h0, 2'd0);
    idle(3);

    applyStimulus(1'b1, 1'b0, 16'h0030, 4'hF, 2'd1);
    applyStimulus(1'b1, 1'b1, 16'h0030, 4'hF, 2'd1);
    applyStimulus(1'b1, 1'b0, 16'h0030, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b1, 16'h0030, 4'hF, 2'd3);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'hF, 2'd2);
    idle(3);

    palWrite(2'd3, 4'd3, 24'h123456);
    applyStimulus(1'b1, 1'b1, 16'h0003, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b1, 16'h0003, 4'hF, 2'd1);
    applyStimulus(1'b1, 1'b1, 16'h0003, 4'hF, 2'd2);
    idle(3);

    pal_we   = 1'b1;
    pal_bank = 2'd1;
    pal_addr = 4'd9;
    pal_data = 24'h5A5A5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      checkOutput("hold_ack", {31'd0, pal_ack}, (i >= 1) ? 32'd1 : 32'd0);
    end
    pal_we = 1'b0;
    @(posedge Clk); #1;
    checkOutput("ack_drop", {31'd0, pal_ack}, 32'd0);
    pal_model[1][9] = 24'h5A5A5A;

    palWrite(2'd2, 4'd7, 24'hAAAAAA);
    palWrite(2'd2, 4'd7, 24'hBBBBBB);
    palWrite(2'd2, 4'd8, 24'hCCCCCC);
    applyStimulus(1'b1, 1'b1, 16'h0007, 4'hF, 2'd2);
    applyStimulus(1'b1, 1'b0, 16'h0800, 4'hF, 2'd2);
    applyStimulus(1'b1, 1'b1, 16'h9000, 4'h8, 2'd1);
    idle(3);

    randomStream(300);
    randomStream(10);
    doReset(1);
    randomStream(200);
    idle(4);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
